// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and debouncer: matrix geometry,
// scan state encoding and key/column index helpers.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
    localparam int unsigned COL_W    = $clog2(NUM_COLS);
    localparam int unsigned KEY_W    = $clog2(NUM_KEYS);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } scan_state_e;

    // Bit position of a key in the snapshot: row * NUM_COLS + col.
    function automatic logic [KEY_W-1:0] key_index(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return KEY_W'(32'(row) * NUM_COLS + 32'(col));
    endfunction

    // Active-low one-hot strobe pattern for a given column.
    function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COL_W-1:0] col);
        return ~(NUM_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned    WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column at a time, captures the
// synchronized rows at the end of each settle window, and publishes one raw
// 16-bit snapshot per frame with a single-cycle valid pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned FRAME_GAP     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [NUM_KEYS-1:0] keys_pressed,
    output logic                frame_valid
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > FRAME_GAP) ? SETTLE_CYCLES : FRAME_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(FRAME_GAP - 1);
    localparam logic [COL_W-1:0] LAST_COL    = COL_W'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_sync;

    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_KEYS-1:0] buf_q, buf_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic                fv_q, fv_d;
    logic [NUM_KEYS-1:0] captured;

    sync_2ff #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_sync)
    );

    // Next-state logic for the scan FSM, settle/gap counter and frame buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        buf_d   = buf_q;
        col_n_d = col_n_q;
        keys_d  = keys_q;
        fv_d    = 1'b0;

        // Buffer as it would look after capturing the current column.
        captured = buf_q;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            captured[key_index(ROW_W'(r), col_q)] = ~row_sync[r];
        end

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            col_d   = '0;
            buf_d   = '0;
            col_n_d = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    col_d   = '0;
                    buf_d   = '0;
                    col_n_d = col_strobe('0);
                end
                DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        buf_d = captured;
                        cnt_d = '0;
                        if (col_q == LAST_COL) begin
                            state_d = GAP;
                            col_n_d = '1;
                            keys_d  = captured;
                            fv_d    = 1'b1;
                        end else begin
                            col_d   = col_q + COL_W'(1);
                            col_n_d = col_strobe(col_q + COL_W'(1));
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        col_d   = '0;
                        buf_d   = '0;
                        col_n_d = col_strobe('0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    col_d   = '0;
                    buf_d   = '0;
                    col_n_d = '1;
                end
            endcase
        end
    end

    // All scanner state and registered outputs; reset overrides enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
            col_n_q <= '1;
            keys_q  <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
            col_n_q <= col_n_d;
            keys_q  <= keys_d;
            fv_q    <= fv_d;
        end
    end

    assign col_n        = col_n_q;
    assign keys_pressed = keys_q;
    assign frame_valid  = fv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the
// rows from the strobed columns; expected snapshots are queued when keys are
// set and compared when frame_valid pulses.
module tb_keypad_scanner;

    typedef struct {
        logic [15:0] keys;
        logic [15:0] expected;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys_pressed;
    logic        frame_valid;

    logic [15:0] pressed;
    logic [15:0] exp_q[$];
    logic [15:0] keys_prev = '0;
    logic        mon_rst;
    bit          mon_en = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    keypad_scanner #(
        .SETTLE_CYCLES (8),
        .FRAME_GAP     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .row_n        (row_n),
        .col_n        (col_n),
        .keys_pressed (keys_pressed),
        .frame_valid  (frame_valid)
    );

    // Keypad matrix: a pressed key shorts its row to its column when that column is low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty, actual=%0h at cycle %0d", name, keys_pressed, cyc);
        end else begin
            e = exp_q.pop_front();
            check(name, keys_pressed, e);
        end
    endtask

    // Waits (bounded) for the next frame_valid, then scores keys_pressed.
    task automatic wait_fv(output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (frame_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL fv_timeout actual=none required=frame_valid within 200 cycles");
        end else begin
            pop_cmp("frame_keys");
        end
    endtask

    // Continuous invariants: at most one column low; keys change only with frame_valid.
    always @(posedge clk) begin
        mon_rst = reset;
        #1;
        if (mon_en) begin
            check("col_n_onehot", 32'($countones(~col_n) <= 1), 1);
            if (!mon_rst && !frame_valid) check("keys_hold", keys_pressed, keys_prev);
        end
        keys_prev = keys_pressed;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[7];
        int          at;
        int          prev;
        int          k;
        logic [3:0]  exp_col;

        vecs[0] = '{keys: 16'h0000, expected: 16'h0000};  // release after 8001
        vecs[1] = '{keys: 16'hFFFF, expected: 16'hFFFF};
        vecs[2] = '{keys: 16'h1248, expected: 16'h1248};  // anti-diagonal
        vecs[3] = '{keys: 16'h00F0, expected: 16'h00F0};  // whole row 1
        vecs[4] = '{keys: 16'h2222, expected: 16'h2222};  // whole column 1
        vecs[5] = '{keys: 16'h0400, expected: 16'h0400};  // r2c2
        vecs[6] = '{keys: 16'h0040, expected: 16'h0040};  // r1c2

        reset   = 1'b1;
        enable  = 1'b0;
        pressed = '0;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        check("rst_col_n", col_n, 4'hF);
        check("rst_keys", keys_pressed, 16'h0000);
        check("rst_fv", frame_valid, 0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Disabled scanner stays idle.
        repeat (100) begin
            @(negedge clk);
            check("idle_col_n", col_n, 4'hF);
            check("idle_keys", keys_pressed, 16'h0000);
            check("idle_fv", frame_valid, 0);
        end

        // Enable with r1c2 pressed: first frame at E0+32, then every 48.
        pressed = 16'h0040;
        exp_q.push_back(16'h0040);
        enable = 1'b1;
        k = cyc;
        wait_fv(at);
        check("first_fv_cycle", at, k + 33);
        @(negedge clk);
        check("fv_one_cycle", frame_valid, 0);
        prev = at;
        repeat (2) begin
            exp_q.push_back(16'h0040);
            wait_fv(at);
            check("frame_period", at, prev + 48);
            prev = at;
        end

        // r0c0 + r3c3, checking the full column strobe sequence of the frame.
        pressed = 16'h8001;
        exp_q.push_back(16'h8001);
        for (int i = 1; i <= 48; i++) begin
            @(negedge clk);
            if (i < 16)      exp_col = 4'hF;
            else if (i < 24) exp_col = 4'hE;
            else if (i < 32) exp_col = 4'hD;
            else if (i < 40) exp_col = 4'hB;
            else if (i < 48) exp_col = 4'h7;
            else             exp_col = 4'hF;
            check($sformatf("col_seq%0d", i), col_n, exp_col);
            if (i < 48) check("no_early_fv", frame_valid, 0);
        end
        check("seq_fv", frame_valid, 1);
        pop_cmp("seq_keys");
        prev = cyc;

        // Table of key patterns, one frame each, changed during the gap.
        for (int i = 0; i < 7; i++) begin
            pressed = vecs[i].keys;
            exp_q.push_back(vecs[i].expected);
            wait_fv(at);
            check($sformatf("vec%0d_period", i), at, prev + 48);
            prev = at;
        end

        // Drop enable in the middle of column 2.
        repeat (34) @(negedge clk);
        check("col2_before_drop", col_n, 4'hB);
        enable  = 1'b0;
        pressed = 16'hFFFF;
        @(negedge clk);
        check("drop_col_n", col_n, 4'hF);
        check("drop_fv", frame_valid, 0);
        check("drop_keys", keys_pressed, 16'h0040);
        repeat (10) begin
            @(negedge clk);
            check("disabled_fv", frame_valid, 0);
            check("disabled_col_n", col_n, 4'hF);
        end
        pressed = 16'h0001;
        exp_q.push_back(16'h0001);
        enable = 1'b1;
        k = cyc;
        wait_fv(at);
        check("restart_fv_cycle", at, k + 33);

        // Reset pulse during the gap while keys_pressed = 0040.
        pressed = 16'h0040;
        exp_q.push_back(16'h0040);
        wait_fv(at);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("gap_rst_keys", keys_pressed, 16'h0000);
        check("gap_rst_col_n", col_n, 4'hF);
        check("gap_rst_fv", frame_valid, 0);
        reset = 1'b0;
        k = cyc;
        exp_q.push_back(16'h0040);
        wait_fv(at);
        check("post_rst_fv_cycle", at, k + 33);
        exp_q.push_back(16'h0040);
        prev = at;
        wait_fv(at);
        check("post_rst_period", at, prev + 48);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
